// File: rtl/conv_encoder_framer.sv
// Rate-1/2 convolutional encoder with frame control and K-1 zero-tail termination.
// Optional error injection on the output symbols is enabled by defining CONV_ENC_ERR_INJ_EN.
module conv_encoder_framer #(
    parameter int             K         = 3,
    parameter logic [K-1:0]   G0        = 3'b111,
    parameter logic [K-1:0]   G1        = 3'b101,
    parameter int             FRAME_LEN = 64,
    parameter int             GAP       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_i,
    input  logic        d_in,
    output logic        ready_o,
    input  logic        abort_i,
    output logic        valid_o,
    output logic [1:0]  d_out,
    output logic        sop_o,
    output logic        eop_o,
    output logic [15:0] frame_cnt_o
`ifdef CONV_ENC_ERR_INJ_EN
    ,
    input  logic [1:0]  err_mask_i,
    output logic [15:0] err_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_TAIL = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam logic [15:0] LAST_BIT  = 16'(FRAME_LEN - 1);
    localparam logic [3:0]  LAST_TAIL = 4'(K - 2);
    localparam logic [3:0]  LAST_GAP  = 4'(GAP - 1);

    state_t        state_r;
    logic [K-2:0]  sr_r;
    logic [15:0]   bit_cnt_r;
    logic [3:0]    tail_cnt_r;
    logic [3:0]    gap_cnt_r;

    logic          accept_s;
    logic          emit_s;
    logic          in_bit_s;
    logic [1:0]    sym_s;
    logic [K-2:0]  sr_next_s;
    logic [1:0]    mask_s;

    function automatic logic parity(input logic [K-1:0] v);
        return ^v;
    endfunction

    function automatic logic [1:0] encode(input logic d, input logic [K-2:0] sr);
        logic [K-1:0] v;
        v = {d, sr};
        return {parity(G0 & v), parity(G1 & v)};
    endfunction

    assign ready_o  = ~rst & ((state_r == S_IDLE) | (state_r == S_DATA));
    assign accept_s = enable_i & ready_o;

`ifdef CONV_ENC_ERR_INJ_EN
    function automatic logic [1:0] popcount2(input logic [1:0] m);
        return {1'b0, m[1]} + {1'b0, m[0]};
    endfunction

    logic [16:0] err_sum_s;
    assign mask_s    = err_mask_i;
    assign err_sum_s = {1'b0, err_cnt_o} + {15'd0, popcount2(mask_s)};

    // Saturating count of output bits flipped by the injection mask
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_o <= 16'd0;
        end else if (emit_s) begin
            err_cnt_o <= err_sum_s[16] ? 16'hFFFF : err_sum_s[15:0];
        end
    end
`else
    assign mask_s = 2'b00;
`endif

    // Symbol to emit this cycle: tail cycles always shift in a zero
    always_comb begin
        emit_s   = 1'b0;
        in_bit_s = d_in;
        if (state_r == S_TAIL) begin
            emit_s   = 1'b1;
            in_bit_s = 1'b0;
        end else if ((state_r == S_IDLE) || (state_r == S_DATA)) begin
            emit_s   = accept_s;
            in_bit_s = d_in;
        end else begin
            emit_s   = 1'b0;
            in_bit_s = 1'b0;
        end
        sym_s     = encode(in_bit_s, sr_r);
        sr_next_s = {in_bit_s, sr_r[K-2:1]};
    end

    // Frame FSM with registered symbol, framing flags and frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            sr_r        <= '0;
            bit_cnt_r   <= 16'd0;
            tail_cnt_r  <= 4'd0;
            gap_cnt_r   <= 4'd0;
            frame_cnt_o <= 16'd0;
            valid_o     <= 1'b0;
            d_out       <= 2'b00;
            sop_o       <= 1'b0;
            eop_o       <= 1'b0;
        end else begin
            valid_o <= emit_s;
            d_out   <= emit_s ? (sym_s ^ mask_s) : 2'b00;
            sop_o   <= 1'b0;
            eop_o   <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        sr_r       <= sr_next_s;
                        sop_o      <= 1'b1;
                        bit_cnt_r  <= 16'd1;
                        tail_cnt_r <= 4'd0;
                        state_r    <= (FRAME_LEN == 1) ? S_TAIL : S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept_s) begin
                        sr_r      <= sr_next_s;
                        bit_cnt_r <= bit_cnt_r + 16'd1;
                    end
                    // Abort with a simultaneous accept still encodes that bit first
                    if ((accept_s && (bit_cnt_r == LAST_BIT)) || abort_i) begin
                        tail_cnt_r <= 4'd0;
                        state_r    <= S_TAIL;
                    end
                end
                S_TAIL: begin
                    sr_r       <= sr_next_s;
                    tail_cnt_r <= tail_cnt_r + 4'd1;
                    if (tail_cnt_r == LAST_TAIL) begin
                        eop_o       <= 1'b1;
                        frame_cnt_o <= frame_cnt_o + 16'd1;
                        bit_cnt_r   <= 16'd0;
                        gap_cnt_r   <= 4'd0;
                        if (GAP == 0) begin
                            sr_r    <= '0;
                            state_r <= S_IDLE;
                        end else begin
                            state_r <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    gap_cnt_r <= gap_cnt_r + 4'd1;
                    if (gap_cnt_r == LAST_GAP) begin
                        sr_r    <= '0;
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    sr_r    <= '0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Scoreboard bench for conv_encoder_framer: two instances (FRAME_LEN=4/GAP=2 and FRAME_LEN=1/GAP=0).
module tb_conv_encoder_framer;

    typedef struct packed {
        logic [1:0] sym;
        logic       sop;
        logic       eop;
        logic       contig;   // symbol must immediately follow the previous one
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en_a, d_a, abort_a, ready_a, valid_a, sop_a, eop_a;
    logic [1:0]  dout_a;
    logic [15:0] fcnt_a;
    logic        en_c, d_c, abort_c, ready_c, valid_c, sop_c, eop_c;
    logic [1:0]  dout_c;
    logic [15:0] fcnt_c;
`ifdef CONV_ENC_ERR_INJ_EN
    logic [1:0]  mask_a;
    logic [15:0] ecnt_a, ecnt_c;
`endif

    exp_t q_a[$];
    exp_t q_c[$];
    int   checks = 0;
    int   errors = 0;
    logic pv_a = 1'b0;
    logic pv_c = 1'b0;

    conv_encoder_framer #(.K(3), .G0(3'b111), .G1(3'b101), .FRAME_LEN(4), .GAP(2)) dut_a (
        .clk(clk), .rst(rst), .enable_i(en_a), .d_in(d_a), .ready_o(ready_a),
        .abort_i(abort_a), .valid_o(valid_a), .d_out(dout_a), .sop_o(sop_a),
        .eop_o(eop_a), .frame_cnt_o(fcnt_a)
`ifdef CONV_ENC_ERR_INJ_EN
        , .err_mask_i(mask_a), .err_cnt_o(ecnt_a)
`endif
    );

    conv_encoder_framer #(.K(3), .G0(3'b111), .G1(3'b101), .FRAME_LEN(1), .GAP(0)) dut_c (
        .clk(clk), .rst(rst), .enable_i(en_c), .d_in(d_c), .ready_o(ready_c),
        .abort_i(abort_c), .valid_o(valid_c), .d_out(dout_c), .sop_o(sop_c),
        .eop_o(eop_c), .frame_cnt_o(fcnt_c)
`ifdef CONV_ENC_ERR_INJ_EN
        , .err_mask_i(2'b00), .err_cnt_o(ecnt_c)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_sym(input string name, input exp_t e, input logic [1:0] d,
                           input logic s, input logic eo, input logic pv);
        checks++;
        if (({d, s, eo} !== {e.sym, e.sop, e.eop}) || (e.contig && !pv)) begin
            errors++;
            $display("FAIL %s: got d_out=%b sop=%b eop=%b prev_valid=%b expected d_out=%b sop=%b eop=%b contig=%b",
                     name, d, s, eo, pv, e.sym, e.sop, e.eop, e.contig);
        end
    endtask

    // Monitor for instance A
    always @(negedge clk) begin
        exp_t e;
        if (valid_a === 1'b1) begin
            if (q_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL sym_a: got unexpected symbol %b, expected none", dout_a);
            end else begin
                e = q_a.pop_front();
                chk_sym("sym_a", e, dout_a, sop_a, eop_a, pv_a);
            end
        end
        pv_a = (valid_a === 1'b1);
    end

    // Monitor for instance C
    always @(negedge clk) begin
        exp_t e;
        if (valid_c === 1'b1) begin
            if (q_c.size() == 0) begin
                checks++; errors++;
                $display("FAIL sym_c: got unexpected symbol %b, expected none", dout_c);
            end else begin
                e = q_c.pop_front();
                chk_sym("sym_c", e, dout_c, sop_c, eop_c, pv_c);
            end
        end
        pv_c = (valid_c === 1'b1);
    end

    task automatic push_a(input logic [1:0] s, input logic sp, input logic ep, input logic ct);
        exp_t e;
        e = '{sym: s, sop: sp, eop: ep, contig: ct};
        q_a.push_back(e);
    endtask

    task automatic push_c(input logic [1:0] s, input logic sp, input logic ep, input logic ct);
        exp_t e;
        e = '{sym: s, sop: sp, eop: ep, contig: ct};
        q_c.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge
    task automatic send_a(input logic b, input logic ab);
        int n;
        n = 0;
        en_a = 1'b1; d_a = b; abort_a = ab;
        while ((ready_a !== 1'b1) && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL send_a: ready_o stuck low, got 0 expected 1");
        end
        @(negedge clk);
        en_a = 1'b0; abort_a = 1'b0;
    endtask

    task automatic ready_low_cycles(input int exp);
        int n;
        n = 0;
        while ((ready_a !== 1'b1) && (n < 50)) begin
            n++;
            @(negedge clk);
        end
        check("ready_low_cycles", n, exp);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (((q_a.size() + q_c.size()) != 0) && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", q_a.size() + q_c.size(), 0);
    endtask

    task automatic push_frame1(input logic [1:0] sym2);
        push_a(2'b11, 1'b1, 1'b0, 1'b0);
        push_a(sym2,  1'b0, 1'b0, 1'b1);
        push_a(2'b00, 1'b0, 1'b0, 1'b1);
        push_a(2'b01, 1'b0, 1'b0, 1'b1);
        push_a(2'b01, 1'b0, 1'b0, 1'b1);
        push_a(2'b11, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        en_a = 1'b0; d_a = 1'b0; abort_a = 1'b0;
        en_c = 1'b0; d_c = 1'b0; abort_c = 1'b0;
`ifdef CONV_ENC_ERR_INJ_EN
        mask_a = 2'b00;
`endif
        #1;
        check("reset_ready", ready_a, 0);
        check("reset_valid", valid_a, 0);
        check("reset_fcnt", fcnt_a, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_ready", ready_a, 1);
        @(negedge clk);

        // Frame 1,0,1,1 on consecutive cycles
`ifdef CONV_ENC_ERR_INJ_EN
        push_frame1(2'b11);
`else
        push_frame1(2'b10);
`endif
        send_a(1'b1, 1'b0);
`ifdef CONV_ENC_ERR_INJ_EN
        mask_a = 2'b01;
`endif
        send_a(1'b0, 1'b0);
`ifdef CONV_ENC_ERR_INJ_EN
        mask_a = 2'b00;
`endif
        send_a(1'b1, 1'b0);
        send_a(1'b1, 1'b0);
        ready_low_cycles(4);
        check("frame_cnt_1", fcnt_a, 1);
`ifdef CONV_ENC_ERR_INJ_EN
        check("err_cnt", ecnt_a, 1);
`endif
        drain();

        // Same frame with enable toggling; tail must follow the 4th symbol directly
        push_a(2'b11, 1'b1, 1'b0, 1'b0);
        push_a(2'b10, 1'b0, 1'b0, 1'b0);
        push_a(2'b00, 1'b0, 1'b0, 1'b0);
        push_a(2'b01, 1'b0, 1'b0, 1'b0);
        push_a(2'b01, 1'b0, 1'b0, 1'b1);
        push_a(2'b11, 1'b0, 1'b1, 1'b1);
        send_a(1'b1, 1'b0); @(negedge clk); check("toggle_idle_valid", valid_a, 0);
        send_a(1'b0, 1'b0); @(negedge clk); check("toggle_idle_valid", valid_a, 0);
        send_a(1'b1, 1'b0); @(negedge clk); check("toggle_idle_valid", valid_a, 0);
        send_a(1'b1, 1'b0);
        ready_low_cycles(4);
        check("frame_cnt_2", fcnt_a, 2);
        drain();

        // Abort together with the 3rd bit
        push_a(2'b11, 1'b1, 1'b0, 1'b0);
        push_a(2'b01, 1'b0, 1'b0, 1'b1);
        push_a(2'b01, 1'b0, 1'b0, 1'b1);
        push_a(2'b11, 1'b0, 1'b0, 1'b1);
        push_a(2'b00, 1'b0, 1'b1, 1'b1);
        send_a(1'b1, 1'b0);
        send_a(1'b1, 1'b0);
        send_a(1'b0, 1'b1);
        ready_low_cycles(4);
        check("frame_cnt_3", fcnt_a, 3);
        drain();

        // Reset in the middle of DATA truncates output immediately
        push_a(2'b11, 1'b1, 1'b0, 1'b0);
        push_a(2'b10, 1'b0, 1'b0, 1'b1);
        send_a(1'b1, 1'b0);
        send_a(1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", valid_a, 0);
        check("midrst_dout", dout_a, 0);
        check("midrst_sop_eop", {sop_a, eop_a}, 0);
        check("midrst_ready", ready_a, 0);
        check("midrst_fcnt", fcnt_a, 0);
        check("midrst_queue", q_a.size(), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_frame1(2'b10);
        send_a(1'b1, 1'b0);
        send_a(1'b0, 1'b0);
        send_a(1'b1, 1'b0);
        send_a(1'b1, 1'b0);
        ready_low_cycles(4);
        check("frame_cnt_after_rst", fcnt_a, 1);
        drain();

        // FRAME_LEN=1, GAP=0: back-to-back frames of bit 1
        for (int f = 0; f < 3; f++) begin
            push_c(2'b11, 1'b1, 1'b0, (f != 0));
            push_c(2'b10, 1'b0, 1'b0, 1'b1);
            push_c(2'b11, 1'b0, 1'b1, 1'b1);
        end
        en_c = 1'b1; d_c = 1'b1;
        repeat (9) @(negedge clk);
        en_c = 1'b0;
        drain();
        check("frame_cnt_c", fcnt_c, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_encoder_framer.md
Name: conv_encoder_framer

Overview:
Rate-1/2 convolutional encoder with frame control. It is the transmit end for the team's Viterbi decoder. It accepts one information bit per handshake and emits a 2-bit code symbol per encoded bit. After each frame it appends K-1 zero tail bits so the trellis returns to state 0, which gives the decoder a known start and end state. It sits between the bit source and the channel/error-injection stage, and its symbol/valid outputs drive the decoder's d_in/enable.

Parameters:
K, 3, constraint length (3..9); shift register holds K-1 bits
G0, 3'b111, generator for d_out[1]; width K; MSB taps the current input bit
G1, 3'b101, generator for d_out[0]; width K; MSB taps the current input bit
FRAME_LEN, 64, information bits per frame (1..65535)
GAP, 2, idle cycles after each tail (0..15); valid_o=0 and ready_o=0 during these

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
enable_i  in  1  input bit valid
d_in  in  1  information bit
ready_o  out  1  encoder can accept a bit this cycle
abort_i  in  1  end current frame early and go to tail
valid_o  out  1  d_out holds a valid symbol
d_out  out  2  code symbol {G0 parity, G1 parity}
sop_o  out  1  first symbol of frame (qualified by valid_o)
eop_o  out  1  last tail symbol of frame (qualified by valid_o)
frame_cnt_o  out  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, sr=0, bit counter=0, frame_cnt_o=0.
  - valid_o, d_out, sop_o, eop_o all 0.
  - ready_o is forced 0 while rst=1.
- ready_o is combinational from state: 1 in IDLE and DATA, 0 in TAIL and GAP.
- A bit is accepted when enable_i && ready_o.
- Encoding:
  - v = {d, sr[K-2:0]}, with sr[K-2] the most recent past bit.
  - d_out[1] = ^(G0 & v); d_out[0] = ^(G1 & v).
  - sr <= {d, sr[K-2:1]}.
- Latency: outputs are registered. valid_o/d_out appear exactly 1 cycle after accept.
- Cycles with no accept in DATA give valid_o=0. sr and the bit counter hold, so gaps in the input do not corrupt encoding.
- FSM states and transitions:
  - IDLE → DATA on accept: encode the bit, set sop_o=1 with that symbol, cnt=1. If FRAME_LEN=1, go straight to TAIL.
  - DATA, accept with cnt==FRAME_LEN-1 → TAIL.
  - DATA, abort_i=1 → TAIL. If an accept happens in the same cycle, that bit is encoded first. Abort with no accept encodes nothing more.
  - TAIL: K-1 cycles, encoding d=0 with valid_o=1 each cycle (input ignored). eop_o=1 on the last tail symbol. frame_cnt_o increments on that cycle. Then → GAP, or → IDLE if GAP=0.
  - GAP: GAP cycles with valid_o=0 → IDLE. At the end of TAIL, sr is 0 by construction; it is also cleared explicitly on entry to IDLE.
- abort_i is ignored in IDLE, TAIL and GAP.
- enable_i while ready_o=0: bit not accepted; the source must hold it.
- Reset mid-frame: output is truncated immediately with no tail. The next frame starts from sr=0.
- sop_o and eop_o are never 1 on the same symbol, since every frame has at least K-1 tail symbols.

Optional Feature:
- Macro: CONV_ENC_ERR_INJ_EN
- Defined:
  - Adds input err_mask_i [1:0]. d_out = encoded symbol ^ err_mask_i, sampled the same cycle the symbol is registered, applied only when that symbol is valid.
  - Adds output err_cnt_o [15:0]: counts flipped bits (popcount of the applied mask). Reset 0; saturates at 0xFFFF.
- Undefined: no extra ports; d_out is always the clean encoded symbol.

Test Plan:
- Default parameters, FRAME_LEN=4, GAP=2. Bits 1,0,1,1 on consecutive cycles → d_out 11,10,00,01 then tail 01,11. sop_o on the first symbol, eop_o on the last. frame_cnt_o=1. ready_o low for 4 cycles (2 tail + 2 gap).
- Same frame with enable_i toggling every other cycle → identical symbol sequence, valid_o low in the gap cycles, tail starts the cycle after the 4th data symbol.
- FRAME_LEN=64, abort_i with accept of the 3rd bit (1,1,0) → symbols 11,01,01 then tail 11,00. eop_o set. Next frame starts from state 0.
- FRAME_LEN=1, GAP=0: back-to-back frames of bit 1 → 11,10,11 repeating. sop_o every 3rd symbol, no idle cycles between frames.
- Assert rst mid-DATA → all outputs 0 at once, ready_o=0. After release, a new frame of 1,0,1,1 reproduces the scenario-1 symbols.
- With CONV_ENC_ERR_INJ_EN, err_mask_i=2'b01 on symbol 2 of scenario 1 → d_out 11,11,00,01,01,11; err_cnt_o=1.
